ila_receiver: RTL
=================

Name: ila_receiver

Overview:
RX link-layer block for JESD204B. It consumes decoded octets from the 8b/10b decoder once code group synchronisation (CGS) is complete. It locates the Initial Lane Alignment (ILA) sequence, checks the /R/, /Q/ and /A/ control-character placement, and captures and checksums the 14-octet link configuration carried in the 2nd multiframe. It reports completion or a specific error to the RX link FSM, and presents the captured config for comparison against local registers.

Parameters:
MIN_MF_OCTETS, 17, minimum legal octets per multiframe; a smaller configured (F+1)*(K+1) raises a parameter error.

Ports:
clk  in  1  character clock
rst_n  in  1  reset, asynchronous, active-low
i_cgs_done  in  1  high while CGS is held; low aborts to IDLE
i_data  in  8  decoded octet, HGFEDCBA
i_k  in  1  i_data is a control character
i_vld  in  1  octet valid; counters advance only on i_vld
i_F  in  8  octets per frame minus 1
i_K  in  5  frames per multiframe minus 1
i_ila_multiframe_length  in  8  ILA multiframes minus 1
o_DID  out  8  captured DID
o_BID  out  4  captured BID
o_LID  out  5  captured LID
o_L  out  5  captured L (encoded)
o_F  out  8  captured F (encoded)
o_K  out  5  captured K (encoded)
o_M  out  8  captured M (encoded)
o_N  out  5  captured N (encoded)
o_N_ap  out  5  captured N' (encoded)
o_CS  out  2  captured CS
o_S  out  5  captured S (encoded)
o_HD  out  1  captured HD
o_CF  out  5  captured CF
o_cfg_vld  out  1  captured config valid; checksum and F/K matched
o_ila_done  out  1  1-cycle pulse on successful ILA end
o_err  out  1  sticky error flag
o_err_code  out  3  sticky: 1 no /R/, 2 no /A/, 3 no /Q/, 4 unexpected K, 5 FCHK, 6 param, 7 F/K mismatch

Behaviour:
- Reset: state IDLE; all outputs 0; octet counter, multiframe counter and checksum accumulator 0.
- Control characters: K28.0 = 0x1C (/R/), K28.3 = 0x7C (/A/), K28.4 = 0x9C (/Q/), K28.5 = 0xBC (/K/).
- Multiframe length: MFL = (i_F+1)*(i_K+1), 11-bit, computed once on the IDLE->WAIT_ILA transition.
- State IDLE: when i_cgs_done=1 -> WAIT_ILA. If MFL < MIN_MF_OCTETS or i_ila_multiframe_length = 0 -> FAIL, code 6.
- State WAIT_ILA: /K/ octets are ignored. A valid /R/ moves to ILA with position p=1 and multiframe m=0. Any valid non-/K/, non-/R/ octet -> FAIL, code 1.
- State ILA, checks on each valid octet at position p (0..MFL-1) of multiframe m:
  - p=0 must be /R/, else code 1.
  - p=MFL-1 must be /A/, else code 2.
  - m=1, p=1 must be /Q/, else code 3.
  - m=1, p=2..15 are config octets 0..13. i_k must be 0, else code 4. Capture per octet index:
    - 0: DID
    - 1: BID=[3:0]
    - 2: LID=[4:0]
    - 3: L=[4:0]
    - 4: F
    - 5: K=[4:0]
    - 6: M
    - 7: CS=[7:6], N=[4:0]
    - 8: N'=[4:0]
    - 9: S=[4:0]
    - 10: HD=[7], CF=[4:0]
    - 11, 12: ignored
    - 13: FCHK
  - FCHK check: mod-256 sum of the field values DID, ADJCNT[7:4], BID, ADJDIR[6], PHADJ[5], LID, SCR[7], L, F, K, M, CS, N, SUBCLASSV[7:5], N', JESDV[7:5], S, HD, CF.
  - All other positions: i_k=1 -> code 4.
- Counters: p wraps MFL-1 -> 0 and increments m.
- End of ILA: at p=MFL-1 with m=i_ila_multiframe_length and /A/ correct, the next cycle:
  - if FCHK mismatch -> FAIL, code 5;
  - else if captured F != i_F or captured K != i_K -> FAIL, code 7;
  - else o_ila_done=1 for one cycle, o_cfg_vld=1, -> DONE.
- Error latency: o_err and o_err_code assert the cycle after the offending octet; state -> FAIL.
- DONE and FAIL hold (outputs stable) until i_cgs_done=0.
- i_cgs_done=0 in any state -> IDLE next cycle; clears o_cfg_vld, o_err, o_err_code and counters. Captured fields keep their last values.
- i_vld=0: no counting, checking or capture; all state held.
- Only the first error is recorded; later octets are ignored.

Test Plan:
- Nominal: i_F=1, i_K=15 (MFL=32), i_ila_multiframe_length=3; 10 /K/ then 128-octet ILA with DID=0x5A, L=3, F=1, K=15, M=7, correct FCHK -> o_ila_done pulse one cycle after octet 127, o_cfg_vld=1, fields match, o_err=0.
- Same stimulus with random i_vld=0 gaps (~30%) -> identical result, done delayed only by gap count.
- FCHK octet +1 -> o_err=1, o_err_code=5, no o_ila_done, o_cfg_vld=0.
- Octet 33 (m=1, p=1) sent as data 0x00 -> o_err_code=3 on the cycle after it.
- Octet 31 sent as 0x00 with i_k=0 instead of /A/ -> o_err_code=2; deassert i_cgs_done -> IDLE, o_err=0 next cycle.
- i_F=0, i_K=7 (MFL=8) with i_cgs_done=1 -> code 6; config F=2 with local i_F=1 -> code 7.

Source files
------------

// File: rtl/ila_receiver.sv
// JESD204B RX initial lane alignment receiver: validates /R/ /Q/ /A/ placement,
// captures and checksums the link configuration, and reports done or first error.
module ila_receiver #(
  parameter int MIN_MF_OCTETS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cgs_done,
  input  logic [7:0] i_data,
  input  logic       i_k,
  input  logic       i_vld,
  input  logic [7:0] i_F,
  input  logic [4:0] i_K,
  input  logic [7:0] i_ila_multiframe_length,
  output logic [7:0] o_DID,
  output logic [3:0] o_BID,
  output logic [4:0] o_LID,
  output logic [4:0] o_L,
  output logic [7:0] o_F,
  output logic [4:0] o_K,
  output logic [7:0] o_M,
  output logic [4:0] o_N,
  output logic [4:0] o_N_ap,
  output logic [1:0] o_CS,
  output logic [4:0] o_S,
  output logic       o_HD,
  output logic [4:0] o_CF,
  output logic       o_cfg_vld,
  output logic       o_ila_done,
  output logic       o_err,
  output logic [2:0] o_err_code
);

  typedef enum logic [2:0] {IDLE, WAIT_ILA, ILA, DONE, FAIL} state_t;

  localparam logic [7:0]  CH_R    = 8'h1C;
  localparam logic [7:0]  CH_A    = 8'h7C;
  localparam logic [7:0]  CH_Q    = 8'h9C;
  localparam logic [7:0]  CH_K    = 8'hBC;
  localparam logic [10:0] MIN_MFL = 11'(MIN_MF_OCTETS);

  state_t      state;
  logic [10:0] mfl_last;
  logic [10:0] pos;
  logic [7:0]  mf;
  logic [7:0]  acc;
  logic [7:0]  fchk;

  logic [8:0]  f_plus;
  logic [5:0]  k_plus;
  logic [10:0] mfl_calc;
  logic        is_r, is_a, is_q, is_kchar;
  logic        cfg_pos;
  logic [7:0]  oct_sum;
  logic [2:0]  ila_code;

  assign f_plus   = {1'b0, i_F} + 9'd1;
  assign k_plus   = {1'b0, i_K} + 6'd1;
  assign mfl_calc = {2'b0, f_plus} * {5'b0, k_plus};

  assign is_r     = i_k && (i_data == CH_R);
  assign is_a     = i_k && (i_data == CH_A);
  assign is_q     = i_k && (i_data == CH_Q);
  assign is_kchar = i_k && (i_data == CH_K);
  assign cfg_pos  = (mf == 8'd1) && (pos >= 11'd2) && (pos <= 11'd15);

  // Checksum contribution of the config octet at the current position (octet index = pos-2)
  always_comb begin
    oct_sum = 8'd0;
    if (cfg_pos) begin
      case (pos[3:0])
        4'd2:  oct_sum = i_data;
        4'd3:  oct_sum = {4'd0, i_data[7:4]} + {4'd0, i_data[3:0]};
        4'd4:  oct_sum = {7'd0, i_data[6]} + {7'd0, i_data[5]} + {3'd0, i_data[4:0]};
        4'd5:  oct_sum = {7'd0, i_data[7]} + {3'd0, i_data[4:0]};
        4'd6:  oct_sum = i_data;
        4'd7:  oct_sum = {3'd0, i_data[4:0]};
        4'd8:  oct_sum = i_data;
        4'd9:  oct_sum = {6'd0, i_data[7:6]} + {3'd0, i_data[4:0]};
        4'd10: oct_sum = {5'd0, i_data[7:5]} + {3'd0, i_data[4:0]};
        4'd11: oct_sum = {5'd0, i_data[7:5]} + {3'd0, i_data[4:0]};
        4'd12: oct_sum = {7'd0, i_data[7]} + {3'd0, i_data[4:0]};
        default: oct_sum = 8'd0;
      endcase
    end
  end

  always_comb begin
    ila_code = 3'd0;
    if (pos == 11'd0)
      ila_code = is_r ? 3'd0 : 3'd1;
    else if (pos == mfl_last)
      ila_code = is_a ? 3'd0 : 3'd2;
    else if ((mf == 8'd1) && (pos == 11'd1))
      ila_code = is_q ? 3'd0 : 3'd3;
    else if (i_k)
      ila_code = 3'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mfl_last   <= '0;
      pos        <= '0;
      mf         <= '0;
      acc        <= '0;
      fchk       <= '0;
      o_DID      <= '0;
      o_BID      <= '0;
      o_LID      <= '0;
      o_L        <= '0;
      o_F        <= '0;
      o_K        <= '0;
      o_M        <= '0;
      o_N        <= '0;
      o_N_ap     <= '0;
      o_CS       <= '0;
      o_S        <= '0;
      o_HD       <= 1'b0;
      o_CF       <= '0;
      o_cfg_vld  <= 1'b0;
      o_ila_done <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= '0;
    end else begin
      o_ila_done <= 1'b0;
      if (!i_cgs_done) begin
        state      <= IDLE;
        pos        <= '0;
        mf         <= '0;
        acc        <= '0;
        o_cfg_vld  <= 1'b0;
        o_err      <= 1'b0;
        o_err_code <= '0;
      end else begin
        case (state)
          IDLE: begin
            mfl_last <= mfl_calc - 11'd1;
            pos      <= '0;
            mf       <= '0;
            acc      <= '0;
            if ((mfl_calc < MIN_MFL) || (i_ila_multiframe_length == 8'd0)) begin
              state      <= FAIL;
              o_err      <= 1'b1;
              o_err_code <= 3'd6;
            end else begin
              state <= WAIT_ILA;
            end
          end
          WAIT_ILA: begin
            if (i_vld && !is_kchar) begin
              if (is_r) begin
                state <= ILA;
                pos   <= 11'd1;
                mf    <= 8'd0;
              end else begin
                state      <= FAIL;
                o_err      <= 1'b1;
                o_err_code <= 3'd1;
              end
            end
          end
          ILA: begin
            if (i_vld) begin
              if (ila_code != 3'd0) begin
                state      <= FAIL;
                o_err      <= 1'b1;
                o_err_code <= ila_code;
              end else begin
                if (cfg_pos) begin
                  acc <= acc + oct_sum;
                  case (pos[3:0])
                    4'd2:  o_DID  <= i_data;
                    4'd3:  o_BID  <= i_data[3:0];
                    4'd4:  o_LID  <= i_data[4:0];
                    4'd5:  o_L    <= i_data[4:0];
                    4'd6:  o_F    <= i_data;
                    4'd7:  o_K    <= i_data[4:0];
                    4'd8:  o_M    <= i_data;
                    4'd9:  begin o_CS <= i_data[7:6]; o_N <= i_data[4:0]; end
                    4'd10: o_N_ap <= i_data[4:0];
                    4'd11: o_S    <= i_data[4:0];
                    4'd12: begin o_HD <= i_data[7]; o_CF <= i_data[4:0]; end
                    4'd15: fchk   <= i_data;
                    default: ;
                  endcase
                end
                if (pos == mfl_last) begin
                  pos <= '0;
                  mf  <= mf + 8'd1;
                  // Last /A/ of the sequence: final verdict on the captured config
                  if (mf == i_ila_multiframe_length) begin
                    if (acc != fchk) begin
                      state      <= FAIL;
                      o_err      <= 1'b1;
                      o_err_code <= 3'd5;
                    end else if ((o_F != i_F) || (o_K != i_K)) begin
                      state      <= FAIL;
                      o_err      <= 1'b1;
                      o_err_code <= 3'd7;
                    end else begin
                      state      <= DONE;
                      o_ila_done <= 1'b1;
                      o_cfg_vld  <= 1'b1;
                    end
                  end
                end else begin
                  pos <= pos + 11'd1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
